// File: rtl/rll_key_pkg.sv
// Shared types and helpers for the RLL16 key loader.
package rll_key_pkg;

  localparam int unsigned DEF_KEY_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  // Even-parity bit: the value that makes the total count of ones even.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rll_key_shift.sv
// Shadow key register with write-position counter; bits arrive LSB first.
module rll_key_shift
  import rll_key_pkg::*;
#(
  parameter int unsigned KEY_W = DEF_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             ser_bit,
  output logic [KEY_W-1:0] shadow,
  output logic             last
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign shadow = shadow_q;
  assign last   = (cnt_q == CNT_W'(KEY_W - 1));

  // Clear wins; otherwise write shadow[cnt] and advance, saturating at KEY_W.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (clr) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (en && (cnt_q < CNT_W'(KEY_W))) begin
      shadow_d = (shadow_q & ~(KEY_W'(1) << cnt_q)) | (KEY_W'(ser_bit) << cnt_q);
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Shadow and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rll_key_loader.sv
// Serial-in key loader for the RLL16 locked netlist. Key stays zero until a
// complete key is committed atomically. Optional trailing even-parity check
// is enabled by defining RLL_KEY_PARITY_EN.
module rll_key_loader
  import rll_key_pkg::*;
#(
  parameter int unsigned KEY_W = DEF_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             shift_en, shift_clr;
  logic [KEY_W-1:0] shadow;
  logic             last;
`ifdef RLL_KEY_PARITY_EN
  logic             err_q, err_d;
  logic             par_ok;
`endif

  rll_key_shift #(.KEY_W(KEY_W)) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (shift_en),
    .clr    (shift_clr),
    .ser_bit(ser_data),
    .shadow (shadow),
    .last   (last)
  );

`ifdef RLL_KEY_PARITY_EN
  assign par_ok = (ser_data == even_parity(64'(shadow)));
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; key_clear overrides every state.
  always_comb begin
    state_d = state_q;
    if (key_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (load_start) state_d = SHIFT;
`ifdef RLL_KEY_PARITY_EN
        SHIFT:  if (ser_valid && last) state_d = CHECK;
        CHECK:  if (ser_valid) state_d = par_ok ? COMMIT : IDLE;
`else
        SHIFT:  if (ser_valid && last) state_d = COMMIT;
        CHECK:  state_d = IDLE;
`endif
        COMMIT: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath control decoded from state.
  always_comb begin
    ser_ready   = (state_q == SHIFT) || (state_q == CHECK);
    busy        = (state_q != IDLE);
    shift_en    = 1'b0;
    shift_clr   = 1'b0;
    key_d       = key_q;
    key_valid_d = key_valid_q;
`ifdef RLL_KEY_PARITY_EN
    err_d       = err_q;
`endif
    if (key_clear) begin
      shift_clr   = 1'b1;
      key_d       = '0;
      key_valid_d = 1'b0;
`ifdef RLL_KEY_PARITY_EN
      err_d       = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            shift_clr = 1'b1;
`ifdef RLL_KEY_PARITY_EN
            err_d     = 1'b0;
`endif
          end
        end
        SHIFT: shift_en = ser_valid;
`ifdef RLL_KEY_PARITY_EN
        CHECK: begin
          if (ser_valid && !par_ok) begin
            err_d     = 1'b1;
            shift_clr = 1'b1;
          end
        end
`endif
        COMMIT: begin
          key_d       = shadow;
          key_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Committed key and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q       <= '0;
      key_valid_q <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
`ifdef RLL_KEY_PARITY_EN
      err_q       <= err_d;
`endif
    end
  end

  assign key_out   = key_q;
  assign key_valid = key_valid_q;
`ifdef RLL_KEY_PARITY_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/rll_key_loader.md
Name: rll_key_loader

Overview:
- Key-delivery end of the RLL16 locked-netlist interface: receives the 16-bit unlock key serially from secure storage/tester and drives the parallel key vector that feeds the locked block's keyIn_0_0..keyIn_0_15 inputs.
- Holds key at all-zero (locked, wrong key) until a complete, checked key is committed atomically.
- Sits between the key-storage serial port and the combinational locked netlist.

Parameters:
- KEY_W, 16, key width in bits; bit i drives keyIn_0_i.
- CNT_W, $clog2(KEY_W+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  synchronous active-low reset
- load_start  input  1  one-cycle pulse; begins a key load when IDLE
- ser_valid  input  1  serial bit present on ser_data
- ser_data  input  1  serial key bit, LSB (key bit 0) first
- ser_ready  output  1  loader accepts a bit this cycle; transfer when ser_valid && ser_ready
- key_clear  input  1  synchronous zeroise request
- key_out  output  KEY_W  committed key to locked netlist
- key_valid  output  1  key_out holds a committed key
- busy  output  1  load in progress (state != IDLE)
- err  output  1  sticky: last load failed check; cleared by next load_start or key_clear

Behaviour:
- Reset (rst_n=0 at clk edge): key_out=0, key_valid=0, busy=0, ser_ready=0, err=0, shadow=0, count=0, state=IDLE. Reset mid-load aborts with no partial commit.
- States: IDLE, SHIFT, CHECK, COMMIT.
- IDLE: ser_ready=0. load_start=1 -> SHIFT, count=0, shadow=0, err=0. key_out/key_valid unchanged during the load (old key stays live until commit).
- SHIFT: ser_ready=1. Each transfer writes shadow[count]=ser_data, count++. ser_valid=0 stalls indefinitely; no timeout. Transfer on count==KEY_W-1 -> CHECK (macro on) or COMMIT (macro off).
- CHECK: see Optional Feature.
- COMMIT: ser_ready=0. key_out<=shadow, key_valid<=1 on this edge -> IDLE. Key visible one cycle after last bit accepted (macro off).
- load_start while busy: ignored.
- key_clear: highest priority after reset. Any state -> IDLE; key_out=0, key_valid=0, shadow=0, err=0. Same-cycle key_clear with load_start: clear wins, no load starts.
- ser_valid in IDLE/COMMIT: ignored, no bit consumed.
- Count never exceeds KEY_W; no wrap.
- All outputs registered except ser_ready and busy, which are decoded from state.

Optional Feature:
- Macro RLL_KEY_PARITY_EN.
- Defined: after KEY_W bits the FSM enters CHECK, ser_ready=1, and one extra transfer carries an even-parity bit over the key.
  - Match -> COMMIT.
  - Mismatch -> err<=1, shadow discarded, previous key_out/key_valid retained, -> IDLE.
  - Commit latency is one cycle after the parity bit.
- Undefined: CHECK is unreachable, err is tied 0, and exactly KEY_W bits are consumed.

Decomposition:
- Package rll_key_pkg: state enum (IDLE, SHIFT, CHECK, COMMIT), KEY_W default constant, function for even parity.
- Sub-module rll_key_shift: shadow register plus bit counter, with inputs en/clr/bit and outputs shadow/last.
- Top keeps the FSM, commit register, and err.

Test Plan:
- Basic load: reset, load_start, 16 beats of 0xA5C3 LSB first with ser_valid held high -> key_out=0xA5C3 and key_valid=1 exactly one cycle after the 16th transfer; busy low next cycle.
- Stalled stream: same key with ser_valid low for 3 cycles between every bit -> identical result; key_out stays at the old value 0x0000 until commit.
- Reload and ignored start: commit 0x1234, then load_start with 0xFFFF, pulsing load_start again mid-load -> second pulse ignored; key_out=0x1234 until final commit, then 0xFFFF.
- Clear and reset mid-load: key_clear after 7 bits -> key_out=0, key_valid=0, IDLE. Separately, rst_n=0 after 10 bits -> all outputs reset; a following full load of 0x0F0F succeeds.
- Parity (RLL_KEY_PARITY_EN): 0xA5C3 (popcount 8) + parity 0 -> commit. 0xA5C3 + parity 1 -> err=1, key_out keeps prior 0x1234. Next load_start clears err.
- Build without macro: 17th serial bit is not consumed (ser_ready=0 after commit), and err stays 0 throughout.
